// File: rtl/line_fill_buffer_pkg.sv
// Shared cache definitions: fill FSM states, default line geometry and
// a words-per-line helper. The word-select mux uses the same constants,
// so both sides agree on how words are laid out in a line.
package line_fill_buffer_pkg;

  localparam int LFB_SEL_WIDTH  = 4;
  localparam int LFB_WORD_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } lfb_state_t;

  function automatic int words_per_line(input int sel_width);
    return 1 << sel_width;
  endfunction

endpackage

// File: rtl/line_fill_buffer_word_slot_writer.sv
// Combinational slot writer: returns the line with one word slot replaced.
// Slot k occupies bits [(k+1)*W-1 : k*W].
module word_slot_writer
  import line_fill_buffer_pkg::*;
#(
  parameter int SEL_WIDTH = LFB_SEL_WIDTH,
  parameter int W         = LFB_WORD_WIDTH
) (
  input  logic [(words_per_line(SEL_WIDTH)*W)-1:0] line,
  input  logic [SEL_WIDTH-1:0]                     index,
  input  logic [W-1:0]                             word,
  input  logic                                     enable,
  output logic [(words_per_line(SEL_WIDTH)*W)-1:0] line_next
);

  localparam int N = words_per_line(SEL_WIDTH);

  // Copy the line through and overwrite only the addressed slot when enabled
  always_comb begin
    line_next = line;
    for (int k = 0; k < N; k++) begin
      if (enable && (index == SEL_WIDTH'(k))) begin
        line_next[k*W +: W] = word;
      end
    end
  end

endmodule

// File: rtl/line_fill_buffer.sv
// Line fill buffer: collects N serial memory beats into one cache line in
// critical-word-first wrap order, forwards the first word early, and
// overlays a pending CPU store word that wins over the beat for its slot.
module line_fill_buffer
  import line_fill_buffer_pkg::*;
#(
  parameter int SEL_WIDTH = LFB_SEL_WIDTH,
  parameter int w         = LFB_WORD_WIDTH
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     start,
  input  logic [SEL_WIDTH-1:0]                     start_idx,
  input  logic                                     merge_en,
  input  logic [SEL_WIDTH-1:0]                     merge_sel,
  input  logic [w-1:0]                             merge_data,
  input  logic                                     beat_valid,
  input  logic [w-1:0]                             beat_data,
  output logic                                     beat_ready,
  output logic                                     crit_valid,
  output logic [w-1:0]                             crit_data,
  output logic                                     line_valid,
  input  logic                                     line_ready,
  output logic [(words_per_line(SEL_WIDTH)*w)-1:0] line_out,
  output logic                                     busy
);

  localparam int N  = words_per_line(SEL_WIDTH);
  localparam int LW = N * w;
  localparam logic [LW-1:0] EMPTY_LINE = '0;

  lfb_state_t           state;
  logic [LW-1:0]        line_q;
  logic [SEL_WIDTH-1:0] ptr;
  logic [SEL_WIDTH-1:0] cnt;
  logic                 m_en;
  logic [SEL_WIDTH-1:0] m_sel;
  logic [w-1:0]         m_data;

  logic                 transfer;
  logic                 merge_hit;
  logic                 beat_wr_en;
  logic [LW-1:0]        beat_line;
  logic [LW-1:0]        start_line;

  assign transfer   = (state == FILL) && beat_valid;
  assign merge_hit  = m_en && (ptr == m_sel);
  assign beat_wr_en = transfer && !merge_hit;
  assign line_out   = line_q;

  word_slot_writer #(.SEL_WIDTH(SEL_WIDTH), .W(w)) u_beat_writer (
    .line      (line_q),
    .index     (ptr),
    .word      (beat_data),
    .enable    (beat_wr_en),
    .line_next (beat_line)
  );

  word_slot_writer #(.SEL_WIDTH(SEL_WIDTH), .W(w)) u_merge_writer (
    .line      (EMPTY_LINE),
    .index     (merge_sel),
    .word      (merge_data),
    .enable    (merge_en),
    .line_next (start_line)
  );

  // Fill FSM with registered handshake outputs; a merged slot keeps the store word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      line_q     <= '0;
      ptr        <= '0;
      cnt        <= '0;
      m_en       <= 1'b0;
      m_sel      <= '0;
      m_data     <= '0;
      crit_valid <= 1'b0;
      crit_data  <= '0;
      beat_ready <= 1'b0;
      line_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      crit_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= FILL;
            ptr        <= start_idx;
            cnt        <= '0;
            m_en       <= merge_en;
            m_sel      <= merge_sel;
            m_data     <= merge_data;
            line_q     <= start_line;
            beat_ready <= 1'b1;
            busy       <= 1'b1;
          end
        end
        FILL: begin
          if (transfer) begin
            line_q <= beat_line;
            ptr    <= ptr + SEL_WIDTH'(1);
            cnt    <= cnt + SEL_WIDTH'(1);
            if (cnt == '0) begin
              crit_valid <= 1'b1;
              crit_data  <= merge_hit ? m_data : beat_data;
            end
            if (cnt == SEL_WIDTH'(N - 1)) begin
              state      <= DONE;
              beat_ready <= 1'b0;
              line_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (line_ready) begin
            state      <= IDLE;
            line_valid <= 1'b0;
            busy       <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          beat_ready <= 1'b0;
          line_valid <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule
